// File: rtl/mem_req_seq.sv
// mem_req_seq: in-order request sequencer in front of the 8-bit mem block.
//   Byte read/write requests arrive over valid/ready and are queued.
//   Queued requests drive mem_rd/mem_wr/mem_din one access at a time.
//   Read data comes back over a valid/ready response port.
//   Only one access is outstanding at a time.
// Optional build macro: MEM_SEQ_CNT_EN adds saturating completed-write and
//   completed-read counters. Without it, wr_cnt and rd_cnt are tied to zero.
// Ports:
//   clk, rst                  clock; synchronous active-low reset
//   req_valid/ready/we/data   request port (req_ready = !full)
//   rsp_valid/ready/data      read-response port
//   busy                      FSM active or queue non-empty
//   mem_rd/wr/din, mem_dout   mem strobes, write data and read data
//   wr_cnt, rd_cnt            completed write/read counters
module mem_req_seq #(
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [7:0]  req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout,
  output logic [15:0] wr_cnt,
  output logic [15:0] rd_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic       we;
    logic [7:0] data;
  } req_t;

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;

  req_t          q [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  state_t        state;
  logic [2:0]    lat;
  logic          push, pop;
  req_t          head;

  // Ready comes from the registered count only, so a pop in the same cycle
  // never frees a slot for that cycle's push.
  assign req_ready = (count != FULL);
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign head      = q[rptr];
  assign busy      = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) q[wptr] <= '{we: req_we, data: req_data};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      lat       <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_din   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      case (state)
        IDLE: if (pop) begin
          if (head.we) begin
            state   <= WRITE;
            mem_wr  <= 1'b1;
            mem_din <= head.data;
          end else begin
            state  <= READ;
            mem_rd <= 1'b1;
          end
        end
        WRITE: begin
          mem_wr <= 1'b0;
          state  <= IDLE;
        end
        // mem samples mem_rd=1 at the edge that leaves READ; data is valid
        // RD_LAT edges later, so count RD_LAT-1 further edges in WAIT.
        READ: begin
          mem_rd <= 1'b0;
          lat    <= 3'(RD_LAT - 1);
          state  <= WAIT;
        end
        WAIT: begin
          if (lat == '0) begin
            rsp_data  <= mem_dout;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            lat <= lat - 1'b1;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_SEQ_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (state == WRITE && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 1'b1;
      if (state == RESP && rsp_ready && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 1'b1;
    end
  end
`else
  assign wr_cnt = '0;
  assign rd_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_req_seq.sv
// Directed bench for mem_req_seq. There are two instances: u_dut with
// RD_LAT=1 and u_dut3 with RD_LAT=3. Each instance has a one-byte mem model.
// The model shows the stored byte on mem_dout for exactly one cycle. That
// cycle is the one ending RD_LAT edges after the edge that sampled mem_rd.
// In every other cycle, mem_dout is 8'hEE, so a capture on any other edge
// returns the wrong data.
module tb_mem_req_seq;
`ifdef MEM_SEQ_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // RD_LAT=1 instance
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, busy, mem_rd, mem_wr;
  logic [7:0]  req_data, rsp_data, mem_din, mem_dout;
  logic [15:0] wr_cnt, rd_cnt;
  // RD_LAT=3 instance
  logic        req_valid3, req_ready3, req_we3, rsp_valid3, rsp_ready3, busy3, mem_rd3, mem_wr3;
  logic [7:0]  req_data3, rsp_data3, mem_din3, mem_dout3;
  logic [15:0] wr_cnt3, rd_cnt3;

  mem_req_seq #(.DEPTH(4), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din), .mem_dout(mem_dout),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt));

  mem_req_seq #(.DEPTH(4), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we3),
    .req_data(req_data3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
    .busy(busy3), .mem_rd(mem_rd3), .mem_wr(mem_wr3), .mem_din(mem_din3), .mem_dout(mem_dout3),
    .wr_cnt(wr_cnt3), .rd_cnt(rd_cnt3));

  // mem models
  logic [7:0] store1 = 8'h00, store3 = 8'h00;
  logic       rdp1 = 1'b0;
  logic [2:0] rdp3 = 3'b000;
  always @(posedge clk) begin
    if (mem_wr)  store1 <= mem_din;
    if (mem_wr3) store3 <= mem_din3;
    rdp1 <= mem_rd;
    rdp3 <= {rdp3[1:0], mem_rd3};
  end
  assign mem_dout  = rdp1    ? store1 : 8'hEE;
  assign mem_dout3 = rdp3[2] ? store3 : 8'hEE;

  int vectors = 0;
  int miscompares = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cx(input int n);
    return CNT_EN ? 16'(n) : 16'h0000;
  endfunction

  initial begin
    rst = 1'b0;
    req_valid = 0; req_we = 0; req_data = 0; rsp_ready = 0;
    req_valid3 = 0; req_we3 = 0; req_data3 = 0; rsp_ready3 = 0;
    // ---- reset state
    step(); step();
    chk("rst_req_ready", 16'(req_ready), 1);
    chk("rst_rsp_valid", 16'(rsp_valid), 0);
    chk("rst_mem_rd",    16'(mem_rd), 0);
    chk("rst_mem_wr",    16'(mem_wr), 0);
    chk("rst_mem_din",   16'(mem_din), 0);
    chk("rst_rsp_data",  16'(rsp_data), 0);
    chk("rst_busy",      16'(busy), 0);
    chk("rst_wr_cnt",    wr_cnt, 0);
    chk("rst_rd_cnt",    rd_cnt, 0);
    rst = 1'b1;

    // ---- test 1: write AA then read
    req_valid = 1; req_we = 1; req_data = 8'hAA; rsp_ready = 1;
    step();                                    // E1 push W
    chk("t1_busy", 16'(busy), 1);
    chk("t1_wr_early", 16'(mem_wr), 0);
    req_we = 0; req_data = 8'h00;
    step();                                    // E2 push R, issue W
    chk("t1_mem_wr", 16'(mem_wr), 1);
    chk("t1_mem_din", 16'(mem_din), 16'h00AA);
    chk("t1_no_rd", 16'(mem_rd), 0);
    req_valid = 0;
    step();                                    // E3
    chk("t1_wr_pulse_end", 16'(mem_wr), 0);
    chk("t1_wr_cnt", wr_cnt, cx(1));
    step();                                    // E4 issue R
    chk("t1_mem_rd", 16'(mem_rd), 1);
    step();                                    // E5
    chk("t1_rd_end", 16'(mem_rd), 0);
    chk("t1_rsp_early", 16'(rsp_valid), 0);
    step();                                    // E6
    chk("t1_rsp_valid", 16'(rsp_valid), 1);
    chk("t1_rsp_data", 16'(rsp_data), 16'h00AA);
    step();                                    // E7 handshake
    chk("t1_rsp_1cyc", 16'(rsp_valid), 0);
    chk("t1_rsp_hold", 16'(rsp_data), 16'h00AA);
    chk("t1_rd_cnt", rd_cnt, cx(1));
    chk("t1_idle", 16'(busy), 0);

    // ---- test 2 + 5: backpressure, full queue, push vs pop
    rsp_ready = 0;
    req_valid = 1; req_we = 1; req_data = 8'h55;
    step();                                    // E8 push W55
    req_we = 0; req_data = 8'h00;
    step();                                    // E9 push R, issue W55
    chk("t2_wr55", 16'(mem_din), 16'h0055);
    req_we = 1; req_data = 8'h0F;
    step();                                    // E10 push W0F
    req_we = 0; req_data = 8'h00;
    step();                                    // E11 push R, issue R
    chk("t2_rd", 16'(mem_rd), 1);
    req_we = 1; req_data = 8'h77;
    step();                                    // E12 push W77
    chk("t2_ready_3", 16'(req_ready), 1);
    req_data = 8'h99;
    step();                                    // E13 push W99 -> full, rsp 55
    chk("t2_full", 16'(req_ready), 0);
    chk("t2_rsp_valid", 16'(rsp_valid), 1);
    chk("t2_rsp55", 16'(rsp_data), 16'h0055);
    req_data = 8'h66;                          // held while full
    for (int i = 0; i < 2; i++) begin          // E14, E15 stalled
      step();
      chk("t2_hold_valid", 16'(rsp_valid), 1);
      chk("t2_hold_data", 16'(rsp_data), 16'h0055);
      chk("t2_no_wr", 16'(mem_wr), 0);
      chk("t2_still_full", 16'(req_ready), 0);
    end
    rsp_ready = 1;
    step();                                    // E16 handshake
    chk("t2_rsp_drop", 16'(rsp_valid), 0);
    chk("t2_data_keep", 16'(rsp_data), 16'h0055);
    chk("t2_full_after_hs", 16'(req_ready), 0);
    step();                                    // E17 pop W0F, push refused
    chk("t2_wr0f", 16'(mem_wr), 1);
    chk("t2_din0f", 16'(mem_din), 16'h000F);
    chk("t5_no_bypass", 16'(req_ready), 1);
    step();                                    // E18 push W66 accepted
    chk("t5_accepted", 16'(req_ready), 0);
    chk("t2_wr0f_end", 16'(mem_wr), 0);
    req_valid = 0;
    step(); step(); step();                    // E19..E21
    chk("t2_rsp_valid2", 16'(rsp_valid), 1);
    chk("t2_rsp0f", 16'(rsp_data), 16'h000F);
    step();                                    // E22
    chk("t2_rsp2_drop", 16'(rsp_valid), 0);
    step();                                    // E23
    chk("t2_din77", 16'(mem_din), 16'h0077);
    step(); step();                            // E25
    chk("t2_din99", 16'(mem_din), 16'h0099);
    step(); step();                            // E27
    chk("t5_din66", 16'(mem_din), 16'h0066);
    chk("t5_wr66", 16'(mem_wr), 1);
    step(); step();                            // E29
    chk("t5_no_dup", 16'(mem_wr), 0);
    chk("t2_drained", 16'(busy), 0);
    chk("t2_wr_cnt", wr_cnt, cx(6));
    chk("t2_rd_cnt", rd_cnt, cx(3));

    // ---- test 4: reset during WAIT
    req_valid = 1; req_we = 0;
    step();                                    // E30 push R
    req_valid = 0;
    step();                                    // E31 READ
    step();                                    // E32 WAIT
    rst = 1'b0;
    step();                                    // E33 reset
    chk("t4_rsp_valid", 16'(rsp_valid), 0);
    chk("t4_mem_rd", 16'(mem_rd), 0);
    chk("t4_mem_wr", 16'(mem_wr), 0);
    chk("t4_busy", 16'(busy), 0);
    chk("t4_req_ready", 16'(req_ready), 1);
    chk("t4_wr_cnt", wr_cnt, 0);
    rst = 1'b1;
    step(); step();
    chk("t4_no_late_rsp", 16'(rsp_valid), 0);

    // ---- test 3 + 6 on RD_LAT=3 instance
    rsp_ready3 = 1;
    req_valid3 = 1; req_we3 = 1; req_data3 = 8'h3C;
    step();                                    // F1 push W3C
    req_we3 = 0; req_data3 = 8'h00;
    step();                                    // F2 push R
    chk("t3_din3c", 16'(mem_din3), 16'h003C);
    req_we3 = 1; req_data3 = 8'h11;
    step();                                    // F3 push W11
    req_data3 = 8'h22;
    step();                                    // F4 push W22, issue R
    chk("t3_mem_rd", 16'(mem_rd3), 1);
    req_we3 = 0; req_data3 = 8'h00;
    step();                                    // F5 push R, mem samples rd
    req_valid3 = 0;
    chk("t3_rd_end", 16'(mem_rd3), 0);
    step(); step();                            // F7
    chk("t3_not_early", 16'(rsp_valid3), 0);
    step();                                    // F8
    chk("t3_rsp_valid", 16'(rsp_valid3), 1);
    chk("t3_rsp3c", 16'(rsp_data3), 16'h003C);
    step();                                    // F9
    chk("t3_rsp_drop", 16'(rsp_valid3), 0);
    step();                                    // F10
    chk("t6_din11", 16'(mem_din3), 16'h0011);
    step(); step();                            // F12
    chk("t6_din22", 16'(mem_din3), 16'h0022);
    for (int i = 0; i < 6; i++) step();        // F18
    chk("t6_rsp22", 16'(rsp_data3), 16'h0022);
    chk("t6_rsp_valid", 16'(rsp_valid3), 1);
    step();                                    // F19
    chk("t6_wr_cnt", wr_cnt3, cx(3));
    chk("t6_rd_cnt", rd_cnt3, cx(2));
    chk("t6_idle", 16'(busy3), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
